// File: rtl/soc_bus_pkg.sv
// Shared definitions for blocks on the SoC memory bus (valid/wen/ready).
package soc_bus_pkg;
   localparam int BUS_AW   = 32;
   localparam int BUS_DW   = 32;
   localparam int BUS_WENW = 4;
   localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_TMO     = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: returns the first set request after position `last`.
module rr_pick
   import soc_bus_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] winner,
   output logic          any
);
   logic [IW-1:0] pos_s;
   logic          hit_s;

   // Walk N positions starting at last+1, keeping the first hit.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      pos_s  = '0;
      hit_s  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         pos_s  = IW'((int'(last) + k) % N);
         hit_s  = !any && req[pos_s];
         winner = hit_s ? pos_s : winner;
         any    = any | hit_s;
      end
   end
endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one memory-bus slave between several masters,
// with a watchdog that terminates accesses the slave never acknowledges.
module rr_mem_arbiter
   import soc_bus_pkg::*;
#(
   parameter int          MASTER_IFACE_CNT = 2,
   parameter int          TIMEOUT_CYCLES   = 1024,
   parameter logic [31:0] ERR_RDATA        = BUS_ERR_RDATA,
   localparam int         IW               = idx_width(MASTER_IFACE_CNT)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [BUS_AW*MASTER_IFACE_CNT-1:0]   addr,
   input  logic [BUS_DW*MASTER_IFACE_CNT-1:0]   wdata,
   output logic [BUS_DW*MASTER_IFACE_CNT-1:0]   rdata,
   input  logic [MASTER_IFACE_CNT-1:0]          valid,
   input  logic [BUS_WENW*MASTER_IFACE_CNT-1:0] wen,
   output logic [MASTER_IFACE_CNT-1:0]          ready,
   output logic [IW-1:0]                        grant_id,
   output logic                                 busy,
   output logic                                 err_flag,
   output logic [IW-1:0]                        err_master,
   input  logic                                 err_clr,
   output logic [BUS_AW-1:0]                    s_addr,
   output logic [BUS_DW-1:0]                    s_wdata,
   input  logic [BUS_DW-1:0]                    s_rdata,
   output logic                                 s_valid,
   output logic [BUS_WENW-1:0]                  s_wen,
   input  logic                                 s_ready
);
   localparam int N  = MASTER_IFACE_CNT;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic          WD_EN     = (TIMEOUT_CYCLES > 0);

   arb_state_t          state_r, state_nxt_s;
   logic [IW-1:0]       grant_r, last_r, err_master_r, pick_s;
   logic                pick_any_s, req_s, wd_hit_s, err_flag_r;
   logic [CW-1:0]       cnt_r;
   logic [BUS_AW-1:0]   addr_a  [N];
   logic [BUS_DW-1:0]   wdata_a [N];
   logic [BUS_WENW-1:0] wen_a   [N];

   for (genvar i = 0; i < N; i++) begin : g_slice
      assign addr_a[i]  = addr[BUS_AW*i +: BUS_AW];
      assign wdata_a[i] = wdata[BUS_DW*i +: BUS_DW];
      assign wen_a[i]   = wen[BUS_WENW*i +: BUS_WENW];
   end

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req    (valid),
      .last   (last_r),
      .winner (pick_s),
      .any    (pick_any_s)
   );

   assign req_s      = valid[grant_r];
   // The counter reads T on the (T+1)th BUSY cycle, so ready lands T+1 cycles after s_valid.
   assign wd_hit_s   = WD_EN && (cnt_r == CNT_LIMIT);
   assign s_addr     = addr_a[grant_r];
   assign s_wdata    = wdata_a[grant_r];
   assign s_wen      = wen_a[grant_r];
   assign busy       = (state_r != ST_IDLE);
   assign grant_id   = grant_r;
   assign err_flag   = err_flag_r;
   assign err_master = err_master_r;

   // State register; reset returns straight to IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state decode: acknowledge beats abort, abort beats watchdog.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:    state_nxt_s = pick_any_s ? ST_BUSY : ST_IDLE;
         ST_BUSY: begin
            if (s_ready)       state_nxt_s = ST_RELEASE;
            else if (!req_s)   state_nxt_s = ST_IDLE;
            else if (wd_hit_s) state_nxt_s = ST_TMO;
            else               state_nxt_s = ST_BUSY;
         end
         ST_TMO:     state_nxt_s = ST_RELEASE;
         ST_RELEASE: state_nxt_s = req_s ? ST_RELEASE : ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Bus-side outputs decoded from the current state.
   always_comb begin
      ready   = '0;
      s_valid = 1'b0;
      rdata   = {N{s_rdata}};
      case (state_r)
         ST_BUSY: begin
            s_valid        = req_s;
            ready[grant_r] = s_ready;
         end
         ST_TMO: begin
            ready[grant_r] = 1'b1;
            rdata          = {N{ERR_RDATA}};
         end
         default: begin
            ready   = '0;
            s_valid = 1'b0;
         end
      endcase
   end

   // Grant, rotation pointer, watchdog counter and sticky error bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_r      <= '0;
         last_r       <= IW'(N - 1);
         cnt_r        <= '0;
         err_flag_r   <= 1'b0;
         err_master_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_any_s) begin
                  grant_r <= pick_s;
                  cnt_r   <= '0;
               end
            end
            ST_BUSY: begin
               if (s_ready || !req_s) last_r <= grant_r;
               if (cnt_r != '1)       cnt_r  <= cnt_r + CW'(1);
            end
            ST_TMO: begin
               last_r       <= grant_r;
               err_master_r <= grant_r;
            end
            default: begin
               last_r <= last_r;
            end
         endcase
         if (state_r == ST_TMO) err_flag_r <= 1'b1;
         else if (err_clr)      err_flag_r <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Self-checking bench for rr_mem_arbiter (N=3 with watchdog, N=2 without) and rr_pick.
module tb_rr_mem_arbiter;
   localparam int NA = 3;
   localparam int TA = 8;
   localparam int NB = 2;
   localparam int TB = 0;
   localparam logic [31:0] ERRV = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: N=3, timeout 8
   logic [95:0] a_addr, a_wdata, a_rdata;
   logic [2:0]  a_valid, a_ready;
   logic [11:0] a_wen;
   logic [1:0]  a_gid, a_emaster;
   logic        a_busy, a_eflag, a_eclr, a_svalid, a_sready;
   logic [31:0] a_saddr, a_swdata, a_srdata;
   logic [3:0]  a_swen;

   // instance B: N=2, watchdog disabled
   logic [63:0] b_addr, b_wdata, b_rdata;
   logic [1:0]  b_valid, b_ready;
   logic [7:0]  b_wen;
   logic        b_gid, b_emaster;
   logic        b_busy, b_eflag, b_eclr, b_svalid, b_sready;
   logic [31:0] b_saddr, b_swdata, b_srdata;
   logic [3:0]  b_swen;

   // standalone finder, N=4
   logic [3:0] p_req;
   logic [1:0] p_last, p_win;
   logic       p_any;

   rr_mem_arbiter #(.MASTER_IFACE_CNT(NA), .TIMEOUT_CYCLES(TA), .ERR_RDATA(ERRV)) dut_a (
      .clk(clk), .reset(reset), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
      .valid(a_valid), .wen(a_wen), .ready(a_ready), .grant_id(a_gid), .busy(a_busy),
      .err_flag(a_eflag), .err_master(a_emaster), .err_clr(a_eclr), .s_addr(a_saddr),
      .s_wdata(a_swdata), .s_rdata(a_srdata), .s_valid(a_svalid), .s_wen(a_swen),
      .s_ready(a_sready));

   rr_mem_arbiter #(.MASTER_IFACE_CNT(NB), .TIMEOUT_CYCLES(TB), .ERR_RDATA(ERRV)) dut_b (
      .clk(clk), .reset(reset), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
      .valid(b_valid), .wen(b_wen), .ready(b_ready), .grant_id(b_gid), .busy(b_busy),
      .err_flag(b_eflag), .err_master(b_emaster), .err_clr(b_eclr), .s_addr(b_saddr),
      .s_wdata(b_swdata), .s_rdata(b_srdata), .s_valid(b_svalid), .s_wen(b_swen),
      .s_ready(b_sready));

   rr_pick #(.N(4), .IW(2)) dut_p (.req(p_req), .last(p_last), .winner(p_win), .any(p_any));

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model for instance A: who owns the bus and how long it has waited.
   int m_owner, m_age, m_last, m_gid, m_emaster;
   bit m_served, m_eflag;

   task automatic model_reset();
      m_owner = -1; m_age = 0; m_served = 1'b0; m_last = NA - 1;
      m_gid = 0; m_eflag = 1'b0; m_emaster = 0;
   endtask

   function automatic bit model_tmo();
      return (m_owner >= 0) && !m_served && (TA > 0) && (m_age == TA + 1);
   endfunction

   // Advance the model by one clock using the inputs that were present at the edge.
   task automatic model_step();
      int c;
      if (model_tmo()) begin
         m_eflag = 1'b1; m_emaster = m_owner; m_last = m_owner; m_served = 1'b1;
      end else begin
         if (a_eclr) m_eflag = 1'b0;
         if (m_owner < 0) begin
            for (int k = 1; k <= NA; k++) begin
               c = (m_last + k) % NA;
               if (a_valid[c]) begin
                  m_owner = c; m_gid = c; m_age = 0; m_served = 1'b0;
                  break;
               end
            end
         end else if (m_served) begin
            if (!a_valid[m_owner]) m_owner = -1;
         end else if (a_sready) begin
            m_last = m_owner; m_served = 1'b1;
         end else if (!a_valid[m_owner]) begin
            m_last = m_owner; m_owner = -1;
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic model_check();
      logic [2:0]  e_ready;
      logic        e_sv;
      logic [31:0] e_rd;
      e_ready = 3'b000; e_sv = 1'b0; e_rd = a_srdata;
      if (m_owner >= 0 && !m_served) begin
         if (model_tmo()) begin
            e_ready[m_owner] = 1'b1; e_rd = ERRV;
         end else begin
            e_sv = a_valid[m_owner]; e_ready[m_owner] = a_sready;
            chk("rnd_saddr", a_saddr, a_addr[32*m_owner +: 32]);
            chk("rnd_swen", a_swen, a_wen[4*m_owner +: 4]);
         end
      end
      chk("rnd_svalid", a_svalid, e_sv);
      chk("rnd_ready", a_ready, e_ready);
      chk("rnd_busy", a_busy, m_owner >= 0);
      chk("rnd_gid", a_gid, m_gid);
      chk("rnd_eflag", a_eflag, m_eflag);
      chk("rnd_emaster", a_emaster, m_emaster);
      chk("rnd_rdata", a_rdata, {3{e_rd}});
   endtask

   typedef struct {
      logic [3:0] req;
      logic [1:0] last;
      logic [1:0] win;
      logic       any;
   } pick_vec_t;
   pick_vec_t pv [12];

   int k, n, prev;
   bit seen;
   logic [2:0] last_ack;

   initial begin
      pv[0]  = '{4'b0000, 2'd3, 2'd0, 1'b0};
      pv[1]  = '{4'b0001, 2'd3, 2'd0, 1'b1};
      pv[2]  = '{4'b0001, 2'd0, 2'd0, 1'b1};
      pv[3]  = '{4'b1111, 2'd0, 2'd1, 1'b1};
      pv[4]  = '{4'b1111, 2'd3, 2'd0, 1'b1};
      pv[5]  = '{4'b1010, 2'd1, 2'd3, 1'b1};
      pv[6]  = '{4'b1010, 2'd3, 2'd1, 1'b1};
      pv[7]  = '{4'b0100, 2'd2, 2'd2, 1'b1};
      pv[8]  = '{4'b1000, 2'd2, 2'd3, 1'b1};
      pv[9]  = '{4'b0110, 2'd1, 2'd2, 1'b1};
      pv[10] = '{4'b0011, 2'd0, 2'd1, 1'b1};
      pv[11] = '{4'b1001, 2'd0, 2'd3, 1'b1};

      reset = 1'b0;
      a_addr = '0; a_wdata = '0; a_valid = '0; a_wen = '0; a_eclr = 1'b0; a_srdata = '0; a_sready = 1'b0;
      b_addr = '0; b_wdata = '0; b_valid = '0; b_wen = '0; b_eclr = 1'b0; b_srdata = '0; b_sready = 1'b0;
      p_req = '0; p_last = '0;

      for (int i = 0; i < 12; i++) begin
         p_req = pv[i].req; p_last = pv[i].last;
         #1;
         chk("pick_any", p_any, pv[i].any);
         if (pv[i].any) chk("pick_win", p_win, pv[i].win);
      end

      // reset state
      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", a_busy, 1'b0);     chk("rst_gid", a_gid, 2'd0);
      chk("rst_eflag", a_eflag, 1'b0);   chk("rst_emaster", a_emaster, 2'd0);
      chk("rst_ready", a_ready, 3'b000); chk("rst_svalid", a_svalid, 1'b0);
      chk("rst_b_busy", b_busy, 1'b0);   chk("rst_b_ready", b_ready, 2'b00);
      @(negedge clk); reset = 1'b1;

      // single master on B: read 0x1000, ack on 2nd BUSY cycle
      @(negedge clk); b_valid = 2'b01; b_addr[31:0] = 32'h0000_1000; #2;
      chk("sm_idle", b_busy, 1'b0);
      @(negedge clk); #2;
      chk("sm_svalid", b_svalid, 1'b1); chk("sm_saddr", b_saddr, 32'h0000_1000);
      chk("sm_gid", b_gid, 1'b0);       chk("sm_wait_ready", b_ready, 2'b00);
      @(negedge clk); b_sready = 1'b1; b_srdata = 32'h1234_5678; #2;
      chk("sm_ready", b_ready, 2'b01);  chk("sm_rdata", b_rdata, {2{32'h1234_5678}});
      @(negedge clk); b_sready = 1'b0; b_valid = 2'b00; #2;
      chk("sm_rel_ready", b_ready, 2'b00); chk("sm_rel_busy", b_busy, 1'b1);
      @(negedge clk); #2;
      chk("sm_back_idle", b_busy, 1'b0);

      // fairness on A: everyone requests, slave acks at once, acked master gaps valid once
      a_sready = 1'b1; last_ack = 3'b000; n = 0; prev = -1;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge clk); a_valid = ~last_ack; #2;
         last_ack = a_ready;
         if (a_ready != 3'b000) begin
            chk("fair_order", a_gid, n % 3);
            if (prev >= 0) chk("fair_no_repeat", a_gid != prev, 1'b1);
            prev = a_gid; n++;
         end
      end
      chk("fair_count", n, 6);
      @(negedge clk); a_valid = 3'b000; a_sready = 1'b0;
      repeat (2) @(negedge clk);

      // timeout: m1 writes, slave never answers
      a_valid = 3'b010; a_wen = 12'h0F0; a_addr[63:32] = 32'h0000_2000; a_wdata[63:32] = 32'hCAFE_0001;
      @(negedge clk); #2;
      chk("tmo_svalid", a_svalid, 1'b1); chk("tmo_gid", a_gid, 2'd1);
      chk("tmo_swen", a_swen, 4'hF);     chk("tmo_swdata", a_swdata, 32'hCAFE_0001);
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); #2;
         if (a_ready != 3'b000) begin k = c; break; end
      end
      chk("tmo_latency", k, 9);           chk("tmo_ready", a_ready, 3'b010);
      chk("tmo_rdata", a_rdata[63:32], ERRV); chk("tmo_svalid_low", a_svalid, 1'b0);
      @(negedge clk); #2;
      chk("tmo_eflag", a_eflag, 1'b1);    chk("tmo_emaster", a_emaster, 2'd1);
      chk("tmo_rel_ready", a_ready, 3'b000);
      @(negedge clk); a_valid = 3'b000; a_eclr = 1'b1;
      @(negedge clk); a_eclr = 1'b0; a_valid = 3'b010; #2;
      chk("eclr_clears", a_eflag, 1'b0);
      k = 0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk); #2;
         if (a_ready != 3'b000) begin k = c; a_eclr = 1'b1; break; end
      end
      chk("tmo2_seen", k, 10);
      @(negedge clk); a_eclr = 1'b0; a_valid = 3'b000; #2;
      chk("tmo2_set_wins", a_eflag, 1'b1);

      // abort: m0 drops valid in BUSY, pending m1 follows
      @(negedge clk); a_valid = 3'b011; #2;
      chk("abort_idle", a_busy, 1'b0);
      @(negedge clk); #2;
      chk("abort_gid", a_gid, 2'd0);     chk("abort_svalid", a_svalid, 1'b1);
      @(negedge clk); a_valid = 3'b010; #2;
      chk("abort_svalid_drop", a_svalid, 1'b0); chk("abort_ready", a_ready, 3'b000);
      @(negedge clk); #2;
      chk("abort_idle_next", a_busy, 1'b0);
      @(negedge clk); #2;
      chk("abort_next_gid", a_gid, 2'd1); chk("abort_next_svalid", a_svalid, 1'b1);

      // asynchronous reset while m2 is in BUSY with s_ready high
      @(negedge clk); a_valid = 3'b100;
      @(negedge clk);
      @(negedge clk); a_sready = 1'b1; #2;
      chk("rst_pre_svalid", a_svalid, 1'b1); chk("rst_pre_ready", a_ready, 3'b100);
      #1 reset = 1'b0; #1;
      chk("rst_async_svalid", a_svalid, 1'b0); chk("rst_async_ready", a_ready, 3'b000);
      chk("rst_async_busy", a_busy, 1'b0);
      @(negedge clk); a_sready = 1'b0; a_valid = 3'b111;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); #2;
      chk("rst_first_grant", a_gid, 2'd0); chk("rst_first_svalid", a_svalid, 1'b1);
      chk("rst_eflag_clear", a_eflag, 1'b0);

      // randomized traffic against the model
      @(negedge clk); a_valid = 3'b000; reset = 1'b0;
      @(negedge clk); reset = 1'b1; model_reset();
      for (int cyc = 0; cyc < 3000 && errors < 20; cyc++) begin
         @(negedge clk);
         model_step();
         for (int i = 0; i < NA; i++) begin
            if (a_valid[i]) a_valid[i] = ($urandom_range(0, 9) != 0);
            else            a_valid[i] = ($urandom_range(0, 2) == 0);
         end
         a_sready = ($urandom_range(0, 5) == 0);
         a_eclr   = ($urandom_range(0, 19) == 0);
         a_addr   = {$urandom, $urandom, $urandom};
         a_wdata  = {$urandom, $urandom, $urandom};
         a_wen    = 12'($urandom);
         a_srdata = $urandom;
         #2;
         model_check();
      end
      @(negedge clk); a_valid = 3'b000; a_sready = 1'b0; a_eclr = 1'b0;

      // watchdog disabled on B: long stall must never complete
      @(negedge clk); b_valid = 2'b01; b_sready = 1'b0; seen = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk); #2;
         if (b_ready != 2'b00 || b_eflag) seen = 1'b1;
      end
      chk("wd_off_quiet", seen, 1'b0);  chk("wd_off_busy", b_busy, 1'b1);
      chk("wd_off_svalid", b_svalid, 1'b1); chk("wd_off_eflag", b_eflag, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
